// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence serializer and the detector bench.
// SEQ_SER_PARITY_EN appends an even-parity bit to every frame.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_t;

    localparam int MAX_GAP = 255;

    // Serial bits per word as seen on the line, including the optional parity bit.
    function automatic int frame_len(input int width);
`ifdef SEQ_SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/seq_ser_hold.sv
// Single-entry holding register in front of the serializer's shift register.
// Push and pop on the same edge keep the entry occupied with the new word.
module seq_ser_hold
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             ready_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        full_d = full_q;
        if (push_i) begin
            full_d = 1'b1;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // The payload needs no reset: it is only observed while full_q is set.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_q <= din_i;
        end
    end

    assign dout_o  = data_q;
    assign full_o  = full_q;
    assign ready_o = !full_q && !rst_i;

endmodule

// File: rtl/sequence_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register and optional inter-word gap.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after each word's LSB.
module sequence_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             busy
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam int GAP_W = 8;

    ser_state_t       state_q, state_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             vld_q, vld_d;

    logic             hold_full, hold_push, hold_pop;
    logic [WIDTH-1:0] hold_word;
    logic             accept, direct_load;

    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SEQ_SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // A word bypasses the holding register only when nothing is in flight.
    assign accept      = din_valid && din_ready;
    assign direct_load = accept && (state_q == S_IDLE) && !hold_full;
    assign hold_push   = accept && !direct_load;

    seq_ser_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (hold_push),
        .pop_i  (hold_pop),
        .din_i  (din),
        .dout_o (hold_word),
        .full_o (hold_full),
        .ready_o(din_ready)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        hold_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_full) begin
                    shift_d  = frame_of(hold_word);
                    hold_pop = 1'b1;
                    bit_d    = '0;
                    state_d  = S_SHIFT;
                end else if (direct_load) begin
                    shift_d = frame_of(din);
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Zero fill leaves the register clear once the last bit has gone out.
                shift_d = shift_q << 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == CNT_W'(FRAME - 1)) begin
                    bit_d = '0;
                    if (GAP > 0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else if (hold_full) begin
                        shift_d  = frame_of(hold_word);
                        hold_pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP - 1)) begin
                    gap_d = '0;
                    if (hold_full) begin
                        shift_d  = frame_of(hold_word);
                        hold_pop = 1'b1;
                        state_d  = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vld_d = (state_d == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            vld_q   <= vld_d;
        end
    end

    assign seq       = shift_q[FRAME-1];
    assign seq_valid = vld_q;
    assign busy      = (state_q != S_IDLE) || hold_full;

endmodule
